// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 frame recovery with registered valid/frame_err strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit and a parity_err strobe.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 busy,
    output logic                 parity_err
`else
    output logic                 busy
`endif
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [SW-1:0]        s_cnt, s_cnt_n;
    logic [BW-1:0]        b_cnt, b_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n, busy_n;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_bit_n, perr_n;
`endif

    // Synchronizer, edge history and all state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= IDLE;
            s_cnt      <= '0;
            b_cnt      <= '0;
            shreg      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_n;
            s_cnt      <= s_cnt_n;
            b_cnt      <= b_cnt_n;
            shreg      <= shreg_n;
            data_out   <= data_n;
            valid      <= valid_n;
            frame_err  <= ferr_n;
            busy       <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= perr_n;
`endif
        end
    end

    // Next-state and strobe logic; counters only move on tick
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        b_cnt_n   = b_cnt;
        shreg_n   = shreg;
        data_n    = data_out;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == S_HALF) begin
                        if (!rx_sync) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            b_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        shreg_n = DATA_BITS'({rx_sync, shreg} >> 1);
                        s_cnt_n = '0;
                        if (b_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            b_cnt_n = b_cnt + BW'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        par_bit_n = rx_sync;
                        s_cnt_n   = '0;
                        state_n   = STOP;
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        // Leave at the stop midpoint so a back-to-back start edge is seen
                        state_n = IDLE;
                        if (rx_sync) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_n  = (^shreg) ^ par_bit;
`endif
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
module tb_uart_rx;

    localparam int BIT_CLK = 64;   // 16 ticks per bit, one tick every 4 clk

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic       rx;
    logic [7:0] data_out;
    logic       valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .busy      (busy),
        .parity_err(parity_err)
`else
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(negedge clk) begin
        tdiv = (tdiv == 3) ? 0 : tdiv + 1;
        tick = (tdiv == 0);
    end

    // Observed strobes
    logic [7:0] got_q[$];
    logic       got_p[$];
    int         ferr_cnt = 0;
    int         viol     = 0;
    logic       valid_d  = 1'b0;
    logic       ferr_d   = 1'b0;

    always @(negedge clk) begin
        if (valid) got_q.push_back(data_out);
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) viol++;
        if ((valid && valid_d) || (frame_err && ferr_d)) viol++;
`ifdef UART_RX_PARITY_EN
        if (valid) got_p.push_back(parity_err);
        if (parity_err && !valid) viol++;
`endif
        valid_d = valid;
        ferr_d  = frame_err;
    end

    // Frame-level reference model
    logic [7:0] exp_q[$];
    logic       exp_p[$];
    int         exp_ferr = 0;
    logic [7:0] exp_last = 8'h00;
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clk(BIT_CLK);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop; model updated from the frame content
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        begin
            logic pb;
            pb = ($countones(d) % 2 == 1) ^ par_flip;
            drive_bit(pb);
            if (stop_bit) exp_p.push_back((($countones(d) + int'(pb)) % 2) == 1);
        end
`endif
        drive_bit(stop_bit);
        if (stop_bit) begin
            exp_q.push_back(d);
            exp_last = d;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":n_valid"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, ":byte"}, got_q[i], exp_q[i]);
`ifdef UART_RX_PARITY_EN
        check({tag, ":n_par"}, got_p.size(), exp_p.size());
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++)
            check({tag, ":parity_err"}, got_p[i], exp_p[i]);
`endif
        check({tag, ":n_ferr"}, ferr_cnt, exp_ferr);
        check({tag, ":data_out"}, data_out, exp_last);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":strobe_shape"}, viol, 0);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(5);
        check("rst:data_out", data_out, 0);
        check("rst:valid", valid, 0);
        check("rst:frame_err", frame_err, 0);
        check("rst:busy", busy, 0);
        rst = 1'b0;
        wait_clk(40);

        // Good frame
        send_frame(8'hA5, 1'b1);
        wait_clk(16);
        check_all("good");

        // Start-bit glitch of 3 ticks, then a real frame
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        wait_clk(BIT_CLK);
        check_all("glitch");
        send_frame(8'h3C, 1'b1);
        wait_clk(16);
        check_all("after_glitch");

        // Framing error with the line held low afterwards (break)
        send_frame(8'h5A, 1'b0);
        rx = 1'b0;
        wait_clk(3 * BIT_CLK);
        check_all("ferr_break");
        rx = 1'b1;
        wait_clk(BIT_CLK);
        check_all("ferr_release");
        send_frame(8'h42, 1'b1);
        wait_clk(16);
        check_all("after_ferr");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_clk(16);
        check_all("b2b");

        // Reset during data bit 4 of 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'hC3 >> i);
        rx = 1'b1 & (8'hC3 >> 4);
        wait_clk(BIT_CLK / 2);
        check("midframe:busy", busy, 1);
        rst = 1'b1;
        #1;
        check("reset:data_out", data_out, 0);
        check("reset:busy", busy, 0);
        exp_last = 8'h00;
        @(negedge clk);
        rx = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(BIT_CLK);
        check_all("post_reset");
        send_frame(8'h7E, 1'b1);
        wait_clk(16);
        check_all("after_reset");

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        wait_clk(16);
        check_all("parity_ok");
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        wait_clk(16);
        check_all("parity_bad");
`endif

        // Random frames, gaps and occasional low stop bits
        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            logic       sb;
            int         gap;
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2);
`ifdef UART_RX_PARITY_EN
            par_flip = 1'($urandom_range(0, 1));
`endif
            send_frame(d, sb);
            if (!sb && gap == 0) gap = 1;
            rx = 1'b1;
            wait_clk(gap * BIT_CLK);
        end
        wait_clk(16);
        check_all("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
